// File: rtl/inst_sequencer.sv
// inst_sequencer: program counter and sequencing engine for the accelerator.
// Fetches 32-bit instructions from a synchronous-read instruction memory,
// executes control opcodes (NOP, HALT, REPEAT, JUMP) locally and dispatches
// datapath opcodes 1..8 over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, start_addr   single-cycle start pulse and first instruction address
//   abort               synchronous flush back to IDLE
//   imem_rd_en/addr     instruction memory read request (data returns next cycle)
//   imem_rdata          instruction memory read data
//   dispatch_valid/inst instruction word offered to the datapath
//   dispatch_ready      datapath accepts the offered word
//   busy                sequencer is running (decoded from state)
//   halted, err         HALT or illegal opcode reached / illegal opcode reached
//   pc                  address of the current instruction
module inst_sequencer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              dispatch_valid,
    output logic [INST_W-1:0] dispatch_inst,
    input  logic              dispatch_ready,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned OPC_W = 4;
    localparam int unsigned PAY_W = INST_W - OPC_W;

    localparam logic [OPC_W-1:0] OP_NOP    = 4'd0;
    localparam logic [OPC_W-1:0] OP_DP_LO  = 4'd1;
    localparam logic [OPC_W-1:0] OP_DP_HI  = 4'd8;
    localparam logic [OPC_W-1:0] OP_HALT   = 4'd9;
    localparam logic [OPC_W-1:0] OP_REPEAT = 4'd10;
    localparam logic [OPC_W-1:0] OP_JUMP   = 4'd11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        DISPATCH = 3'd3,
        HALTED   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [PAY_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic                rep_pend_q, rep_pend_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;

    logic [OPC_W-1:0]    opcode;
    logic [PAY_W-1:0]    payload;
    logic [ADDR_W-1:0]   pc_inc;

    assign opcode  = imem_rdata[INST_W-1 -: OPC_W];
    assign payload = imem_rdata[PAY_W-1:0];
    assign pc_inc  = pc_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rep_cnt_d  = rep_cnt_q;
        rep_pend_d = rep_pend_q;
        inst_d     = inst_q;
        halted_d   = halted_q;
        err_d      = err_q;

        if (abort) begin
            // pc, halted and err deliberately hold across an abort
            state_d    = IDLE;
            rep_pend_d = 1'b0;
            rep_cnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE, HALTED: begin
                    if (start) begin
                        state_d    = FETCH;
                        pc_d       = start_addr;
                        halted_d   = 1'b0;
                        err_d      = 1'b0;
                        rep_pend_d = 1'b0;
                        rep_cnt_d  = '0;
                    end
                end
                FETCH: begin
                    state_d = DECODE;
                end
                DECODE: begin
                    inst_d     = imem_rdata;
                    rep_pend_d = 1'b0;
                    if (opcode == OP_NOP) begin
                        rep_cnt_d = '0;
                        pc_d      = pc_inc;
                        state_d   = FETCH;
                    end else if (opcode == OP_HALT) begin
                        rep_cnt_d = '0;
                        halted_d  = 1'b1;
                        state_d   = HALTED;
                    end else if (opcode == OP_REPEAT) begin
                        // A second REPEAT simply overwrites the pending count
                        rep_cnt_d  = payload;
                        rep_pend_d = 1'b1;
                        pc_d       = pc_inc;
                        state_d    = FETCH;
                    end else if (opcode == OP_JUMP) begin
                        rep_cnt_d = '0;
                        pc_d      = payload[ADDR_W-1:0];
                        state_d   = FETCH;
                    end else if (opcode >= OP_DP_LO && opcode <= OP_DP_HI) begin
                        if (!rep_pend_q) begin
                            rep_cnt_d = PAY_W'(1);
                            state_d   = DISPATCH;
                        end else if (rep_cnt_q == '0) begin
                            // REPEAT 0 skips the following instruction
                            pc_d    = pc_inc;
                            state_d = FETCH;
                        end else begin
                            state_d = DISPATCH;
                        end
                    end else begin
                        // Opcodes 12..15 are illegal
                        rep_cnt_d = '0;
                        halted_d  = 1'b1;
                        err_d     = 1'b1;
                        state_d   = HALTED;
                    end
                end
                DISPATCH: begin
                    if (valid_q && dispatch_ready) begin
                        if (rep_cnt_q > PAY_W'(1)) begin
                            rep_cnt_d = rep_cnt_q - PAY_W'(1);
                        end else begin
                            rep_cnt_d = '0;
                            pc_d      = pc_inc;
                            state_d   = FETCH;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Registered outputs are derived from the next state so they align with it
        rd_en_d = (state_d == FETCH);
        addr_d  = (state_d == FETCH) ? pc_d : addr_q;
        valid_d = (state_d == DISPATCH);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            rep_cnt_q  <= '0;
            rep_pend_q <= 1'b0;
            inst_q     <= '0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_pend_q <= rep_pend_d;
            inst_q     <= inst_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_rd_en     = rd_en_q;
    assign imem_addr      = addr_q;
    assign dispatch_valid = valid_q;
    assign dispatch_inst  = inst_q;
    assign halted         = halted_q;
    assign err            = err_q;
    assign pc             = pc_q;
    assign busy           = (state_q != IDLE) && (state_q != HALTED);

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed testbench for inst_sequencer: linear program, backpressure,
// REPEAT 3 / REPEAT 0, JUMP and pc wrap, illegal opcode, abort and async reset.
module tb_inst_sequencer;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned INST_W = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              abort;
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              dispatch_valid;
    logic [INST_W-1:0] dispatch_inst;
    logic              dispatch_ready;
    logic              busy;
    logic              halted;
    logic              err;
    logic [ADDR_W-1:0] pc;

    inst_sequencer #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_addr     (start_addr),
        .abort          (abort),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .dispatch_valid (dispatch_valid),
        .dispatch_inst  (dispatch_inst),
        .dispatch_ready (dispatch_ready),
        .busy           (busy),
        .halted         (halted),
        .err            (err),
        .pc             (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read instruction memory
    logic [INST_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    // Handshake monitor: log accepted words and the cycle they were accepted in
    int          cyc;
    int          hs_cnt;
    logic [31:0] hs_word [0:255];
    int          hs_cyc  [0:255];
    initial begin
        cyc    = 0;
        hs_cnt = 0;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && dispatch_valid && dispatch_ready && hs_cnt < 256) begin
            hs_word[hs_cnt] <= dispatch_inst;
            hs_cyc[hs_cnt]  <= cyc;
            hs_cnt          <= hs_cnt + 1;
        end
    end

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " imem_rd_en"},     32'(imem_rd_en),     32'd0);
        check({tag, " imem_addr"},      32'(imem_addr),      32'd0);
        check({tag, " dispatch_valid"}, 32'(dispatch_valid), 32'd0);
        check({tag, " dispatch_inst"},  dispatch_inst,       32'd0);
        check({tag, " busy"},           32'(busy),           32'd0);
        check({tag, " halted"},         32'(halted),         32'd0);
        check({tag, " err"},            32'(err),            32'd0);
        check({tag, " pc"},             32'(pc),             32'd0);
    endtask

    // Pulse start for one cycle; returns at the negedge of the first FETCH cycle
    task automatic do_start(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " reached halt"}, 32'(halted), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!dispatch_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " dispatch_valid seen"}, 32'(dispatch_valid), 32'd1);
    endtask

    int base;

    initial begin
        n_vec          = 0;
        n_err          = 0;
        start          = 1'b0;
        start_addr     = '0;
        abort          = 1'b0;
        dispatch_ready = 1'b1;
        rst_n          = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h9000_0000;

        mem[0]     = 32'h1001_0020;  // test 1
        mem[1]     = 32'h2000_0000;
        mem[2]     = 32'h9000_0000;
        mem[4]     = 32'hF000_0000;  // test 6 illegal
        mem[5]     = 32'hBFFF_F010;  // test 5 jump
        mem[8]     = 32'h1ABC_DEF0;  // test 2 backpressure
        mem[16]    = 32'hA000_0003;  // test 3 REPEAT 3
        mem[17]    = 32'h3ABC_0000;
        mem[24]    = 32'hA000_0000;  // test 4 REPEAT 0
        mem[25]    = 32'h1000_0001;
        mem[32]    = 32'hA000_0005;  // abort mid-REPEAT
        mem[33]    = 32'h4000_0000;
        mem[40]    = 32'h5000_0000;  // reset during dispatch
        mem[12'hFFF] = 32'h0000_0000;  // NOP at top of memory

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post-reset idle");

        // Test 1: linear program
        base = hs_cnt;
        do_start(12'd0);
        check("t1 fetch rd_en", 32'(imem_rd_en), 32'd1);
        check("t1 fetch addr",  32'(imem_addr),  32'd0);
        check("t1 busy",        32'(busy),       32'd1);
        wait_halt("t1");
        check("t1 dispatch count", 32'(hs_cnt - base), 32'd2);
        check("t1 word0", hs_word[base],     32'h1001_0020);
        check("t1 word1", hs_word[base + 1], 32'h2000_0000);
        check("t1 err",  32'(err),  32'd0);
        check("t1 pc",   32'(pc),   32'd2);
        check("t1 busy", 32'(busy), 32'd0);

        // Test 2: backpressure on a MATMUL
        base = hs_cnt;
        dispatch_ready = 1'b0;
        do_start(12'd8);
        wait_valid("t2");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2 valid held", 32'(dispatch_valid), 32'd1);
            check("t2 inst held",  dispatch_inst,       32'h1ABC_DEF0);
        end
        check("t2 no handshake yet", 32'(hs_cnt - base), 32'd0);
        dispatch_ready = 1'b1;
        wait_halt("t2");
        check("t2 one handshake", 32'(hs_cnt - base), 32'd1);
        check("t2 word", hs_word[base], 32'h1ABC_DEF0);

        // Test 3: REPEAT 3 -> three back-to-back handshakes, then pc+1
        base = hs_cnt;
        do_start(12'd16);
        wait_halt("t3");
        check("t3 count", 32'(hs_cnt - base), 32'd3);
        for (int i = 0; i < 3; i++) check("t3 word", hs_word[base + i], 32'h3ABC_0000);
        check("t3 back-to-back", 32'(hs_cyc[base + 2] - hs_cyc[base]), 32'd2);
        check("t3 pc", 32'(pc), 32'd18);

        // Test 4: REPEAT 0 skips the MATMUL
        base = hs_cnt;
        do_start(12'd24);
        wait_halt("t4");
        check("t4 count", 32'(hs_cnt - base), 32'd0);
        check("t4 pc", 32'(pc), 32'd26);

        // Test 5: JUMP drops upper payload bits; NOP at 0xFFF wraps to 0
        mem[0] = 32'h9000_0000;
        mem[16] = 32'h9000_0000;
        base = hs_cnt;
        do_start(12'd5);
        check("t5 fetch jump addr", 32'(imem_addr), 32'h005);
        @(negedge clk);
        check("t5 decode rd_en", 32'(imem_rd_en), 32'd0);
        @(negedge clk);
        check("t5 target rd_en", 32'(imem_rd_en), 32'd1);
        check("t5 target addr",  32'(imem_addr),  32'h010);
        wait_halt("t5 jump");
        check("t5 jump pc", 32'(pc), 32'h010);
        do_start(12'hFFF);
        check("t5 fetch top", 32'(imem_addr), 32'hFFF);
        repeat (2) @(negedge clk);
        check("t5 wrap rd_en", 32'(imem_rd_en), 32'd1);
        check("t5 wrap addr",  32'(imem_addr),  32'h000);
        wait_halt("t5 wrap");
        check("t5 wrap pc", 32'(pc), 32'd0);
        check("t5 no dispatch", 32'(hs_cnt - base), 32'd0);

        // Test 6a: illegal opcode, then start clears err
        base = hs_cnt;
        do_start(12'd4);
        wait_halt("t6 illegal");
        check("t6 err",    32'(err),   32'd1);
        check("t6 pc",     32'(pc),    32'd4);
        check("t6 busy",   32'(busy),  32'd0);
        check("t6 no dispatch", 32'(hs_cnt - base), 32'd0);
        do_start(12'd0);
        check("t6 err cleared",    32'(err),    32'd0);
        check("t6 halted cleared", 32'(halted), 32'd0);
        wait_halt("t6 restart");
        check("t6 err stays clear", 32'(err), 32'd0);

        // Test 6b: abort mid-REPEAT
        do_start(12'd32);
        wait_valid("t6 abort");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort valid", 32'(dispatch_valid), 32'd0);
        check("abort busy",  32'(busy),           32'd0);
        check("abort rd_en", 32'(imem_rd_en),     32'd0);
        check("abort pc held", 32'(pc),           32'd33);
        base = hs_cnt;
        repeat (4) @(negedge clk);
        check("abort no further dispatch", 32'(hs_cnt - base), 32'd0);
        // Pending repeat count must not survive the abort
        do_start(12'd33);
        wait_halt("abort rerun");
        check("abort rerun count", 32'(hs_cnt - base), 32'd1);
        check("abort rerun pc", 32'(pc), 32'd34);

        // abort wins over start in the same cycle
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        start_addr = 12'd0;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort>start rd_en",  32'(imem_rd_en), 32'd0);
        check("abort>start busy",   32'(busy),       32'd0);
        check("abort>start halted", 32'(halted),     32'd1);
        check("abort>start pc",     32'(pc),         32'd34);

        // Test 6c: asynchronous reset during DISPATCH
        dispatch_ready = 1'b0;
        base = hs_cnt;
        do_start(12'd40);
        wait_valid("reset");
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        dispatch_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset no handshake", 32'(hs_cnt - base), 32'd0);
        check("reset stays idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
